// File: rtl/mem_seq_if.sv
// Shared types for the SRAM-side command bus, and the bundled request/response
// plus mem-side bus that connects mem_seq to its CPU and to the SRAM block.
package mem_types;
    typedef logic [15:0] addr_t;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} cmd_t;
endpackage

interface mem_seq_if;
    import mem_types::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    addr_t       req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    cmd_t        mem_cmd;
    addr_t       mem_addr;
    logic [7:0]  mem_write_data;
    logic [7:0]  mem_read_data;

    // Sequencer view
    modport slave (
        input  req_valid, req_write, req_word, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, mem_cmd, mem_addr, mem_write_data
    );

    // Requester / memory-model view
    modport master (
        output req_valid, req_write, req_word, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, mem_cmd, mem_addr, mem_write_data
    );
endinterface

// File: rtl/mem_seq.sv
// Memory access sequencer: splits byte/word CPU requests into byte accesses
// on the SRAM command bus (write = CMD cycle then HOLD cycle, reads are
// combinational) and returns a one-cycle response pulse.
module mem_seq #(
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    mem_seq_if.slave   bus
);
    import mem_types::*;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RD_LO      = 3'd1;
    localparam logic [2:0] RD_HI      = 3'd2;
    localparam logic [2:0] WR_CMD_LO  = 3'd3;
    localparam logic [2:0] WR_HOLD_LO = 3'd4;
    localparam logic [2:0] WR_CMD_HI  = 3'd5;
    localparam logic [2:0] WR_HOLD_HI = 3'd6;
    localparam logic [2:0] RESP       = 3'd7;

    logic [2:0]  state_reg, state_next;
    logic        word_reg;
    logic [15:0] wdata_reg;
    addr_t       mem_addr_reg;
    logic [7:0]  mem_wdata_reg;
    wire  [15:0] rdata_bus;

    logic       accept;
    logic [7:0] first_wbyte;
    logic [7:0] second_wbyte;
    logic       first_lane_hi;
    logic       second_lane_hi;

    assign accept = bus.req_valid && (state_reg == IDLE);

    // Byte written at addr: low byte in little-endian order, high byte otherwise;
    // a byte access always writes req_wdata[7:0].
    assign first_wbyte  = (bus.req_word && !LITTLE_ENDIAN) ? bus.req_wdata[15:8]
                                                           : bus.req_wdata[7:0];
    assign second_wbyte = LITTLE_ENDIAN ? wdata_reg[15:8] : wdata_reg[7:0];

    // Result lane that each captured byte lands in.
    assign first_lane_hi  = word_reg && !LITTLE_ENDIAN;
    assign second_lane_hi = LITTLE_ENDIAN;

    // Next-state selection
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (accept) state_next = bus.req_write ? WR_CMD_LO : RD_LO;
            RD_LO:      state_next = word_reg ? RD_HI : RESP;
            RD_HI:      state_next = RESP;
            WR_CMD_LO:  state_next = WR_HOLD_LO;
            WR_HOLD_LO: state_next = word_reg ? WR_CMD_HI : RESP;
            WR_CMD_HI:  state_next = WR_HOLD_HI;
            WR_HOLD_HI: state_next = RESP;
            RESP:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight request without a response
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Request latch and mem address/data, held across each CMD+HOLD pair
    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg      <= 1'b0;
            wdata_reg     <= 16'h0000;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 8'h00;
        end else if (accept) begin
            word_reg      <= bus.req_word;
            wdata_reg     <= bus.req_wdata;
            mem_addr_reg  <= bus.req_addr;
            mem_wdata_reg <= first_wbyte;
        end else if (word_reg && (state_reg == RD_LO || state_reg == WR_HOLD_LO)) begin
            // addr+1 wraps naturally at the top of the address space
            mem_addr_reg  <= mem_addr_reg + addr_t'(1);
            if (state_reg == WR_HOLD_LO) mem_wdata_reg <= second_wbyte;
        end
    end

    // One capture register per result byte lane
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic       hit;
            localparam bit IS_HI = (gi == 1);

            assign hit = ((state_reg == RD_LO) && (first_lane_hi  == IS_HI)) ||
                         ((state_reg == RD_HI) && (second_lane_hi == IS_HI));

            // Cleared on accept so writes and byte reads return zero-filled data
            always_ff @(posedge clk) begin
                if (reset)       lane_reg <= 8'h00;
                else if (accept) lane_reg <= 8'h00;
                else if (hit)    lane_reg <= bus.mem_read_data;
            end

            assign rdata_bus[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    assign bus.req_ready      = (state_reg == IDLE);
    assign bus.resp_valid     = (state_reg == RESP);
    assign bus.resp_rdata     = rdata_bus;
    assign bus.mem_addr       = mem_addr_reg;
    assign bus.mem_write_data = mem_wdata_reg;
    // WRITE only in the command cycles, suppressed while reset is asserted
    assign bus.mem_cmd = (!reset && (state_reg == WR_CMD_LO || state_reg == WR_CMD_HI))
                         ? mem_types::WRITE : mem_types::READ;
endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: a little-endian and a big-endian instance run in
// lockstep from the same stimulus, each against its own byte-wide SRAM model.
module tb_mem_seq;
    import mem_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic        req_word;
    addr_t       req_addr;
    logic [15:0] req_wdata;

    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];

    mem_seq_if if0();
    mem_seq_if if1();

    assign if0.req_valid = req_valid;
    assign if0.req_write = req_write;
    assign if0.req_word  = req_word;
    assign if0.req_addr  = req_addr;
    assign if0.req_wdata = req_wdata;
    assign if0.mem_read_data = mem0[if0.mem_addr];

    assign if1.req_valid = req_valid;
    assign if1.req_write = req_write;
    assign if1.req_word  = req_word;
    assign if1.req_addr  = req_addr;
    assign if1.req_wdata = req_wdata;
    assign if1.mem_read_data = mem1[if1.mem_addr];

    mem_seq #(.LITTLE_ENDIAN(1'b1)) u0 (.clk(clk), .reset(reset), .bus(if0));
    mem_seq #(.LITTLE_ENDIAN(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1));

    // SRAM model state: a WRITE seen at one edge is performed at the next edge
    logic       pend0, pend1;
    addr_t      wa0, wa1;
    logic [7:0] wd0, wd1;
    int         wr_cmd0, wr_cmd1;

    int vectors;
    int miscompares;

    // Advance one clock; also steps the SRAM models. Returns 1 time unit after the edge.
    task automatic tick();
        logic p0, p1;
        addr_t a0, a1;
        logic [7:0] d0, d1;
        #1;
        p0 = (if0.mem_cmd === WRITE);
        p1 = (if1.mem_cmd === WRITE);
        a0 = if0.mem_addr; d0 = if0.mem_write_data;
        a1 = if1.mem_addr; d1 = if1.mem_write_data;
        if (p0) wr_cmd0++;
        if (p1) wr_cmd1++;
        @(posedge clk);
        if (pend0) mem0[wa0] = wd0;
        if (pend1) mem1[wa1] = wd1;
        pend0 = p0; wa0 = a0; wd0 = d0;
        pend1 = p1; wa1 = a1; wd1 = d1;
        #1;
    endtask

    // Issue one request and wait (bounded) for its response pulse.
    task automatic do_req(input logic w, input logic wd, input addr_t a, input logic [15:0] d,
                          output int lat, output logic [15:0] r0, output logic [15:0] r1,
                          output logic extra);
        req_valid = 1'b1; req_write = w; req_word = wd; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (if0.resp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        r0 = if0.resp_rdata;
        r1 = if1.resp_rdata;
        tick();
        extra = if0.resp_valid;
        $display("txn write=%0d word=%0d addr=%h wdata=%h latency=%0d rdata_le=%h rdata_be=%h",
                 w, wd, a, d, lat, r0, r1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_word = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0;
        tick();
        tick();
        vectors++; if (if0.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", if0.req_ready); end
        vectors++; if (if1.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_be: got %b expected 1", if1.req_ready); end
        vectors++; if (if0.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0", if0.resp_valid); end
        vectors++; if (if0.resp_rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0000", if0.resp_rdata); end
        vectors++; if (if0.mem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 0000", if0.mem_addr); end
        vectors++; if (if0.mem_write_data !== 8'h00) begin miscompares++; $display("FAIL reset_mem_wdata: got %h expected 00", if0.mem_write_data); end
        vectors++; if (if0.mem_cmd !== READ) begin miscompares++; $display("FAIL reset_mem_cmd: got %0d expected READ", if0.mem_cmd); end
        req_valid = 1'b0;
        reset = 1'b0;
        tick();
        vectors++; if (if0.req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b expected 1", if0.req_ready); end
    endtask

    task automatic test_byte();
        int w0, lat;
        logic [15:0] r0, r1;
        logic extra;
        w0 = wr_cmd0;
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b0; req_addr = 16'h0010; req_wdata = 16'h55A5;
        tick();
        req_valid = 1'b0;
        vectors++; if (if0.mem_cmd !== WRITE) begin miscompares++; $display("FAIL bw_cmd1: got %0d expected WRITE", if0.mem_cmd); end
        vectors++; if (if0.mem_addr !== 16'h0010) begin miscompares++; $display("FAIL bw_addr1: got %h expected 0010", if0.mem_addr); end
        vectors++; if (if0.mem_write_data !== 8'hA5) begin miscompares++; $display("FAIL bw_data1: got %h expected a5", if0.mem_write_data); end
        vectors++; if (if0.req_ready !== 1'b0) begin miscompares++; $display("FAIL bw_ready1: got %b expected 0", if0.req_ready); end
        tick();
        vectors++; if (if0.mem_cmd !== READ) begin miscompares++; $display("FAIL bw_cmd2: got %0d expected READ", if0.mem_cmd); end
        vectors++; if (if0.mem_addr !== 16'h0010) begin miscompares++; $display("FAIL bw_addr2: got %h expected 0010", if0.mem_addr); end
        vectors++; if (if0.mem_write_data !== 8'hA5) begin miscompares++; $display("FAIL bw_data2: got %h expected a5", if0.mem_write_data); end
        tick();
        vectors++; if (if0.resp_valid !== 1'b1) begin miscompares++; $display("FAIL bw_resp: got %b expected 1", if0.resp_valid); end
        vectors++; if (if0.resp_rdata !== 16'h0000) begin miscompares++; $display("FAIL bw_resp_rdata: got %h expected 0000", if0.resp_rdata); end
        tick();
        vectors++; if (if0.resp_valid !== 1'b0) begin miscompares++; $display("FAIL bw_resp_len: got %b expected 0", if0.resp_valid); end
        vectors++; if (wr_cmd0 - w0 !== 1) begin miscompares++; $display("FAIL bw_write_cmds: got %0d expected 1", wr_cmd0 - w0); end
        vectors++; if (mem0[16'h0010] !== 8'hA5) begin miscompares++; $display("FAIL bw_mem: got %h expected a5", mem0[16'h0010]); end
        $display("txn write=1 word=0 addr=0010 wdata=55a5 latency=3");
        mem0[16'h0011] = 8'hFF;
        do_req(1'b0, 1'b0, 16'h0010, 16'h0, lat, r0, r1, extra);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL br_latency: got %0d expected 2", lat); end
        vectors++; if (r0 !== 16'h00A5) begin miscompares++; $display("FAIL br_rdata: got %h expected 00a5", r0); end
        vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL br_resp_len: got %b expected 0", extra); end
    endtask

    task automatic test_word();
        int lat;
        logic [15:0] r0, r1;
        logic extra;
        do_req(1'b1, 1'b1, 16'h0020, 16'h1234, lat, r0, r1, extra);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL ww_latency: got %0d expected 5", lat); end
        vectors++; if (r0 !== 16'h0000) begin miscompares++; $display("FAIL ww_rdata: got %h expected 0000", r0); end
        vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL ww_resp_len: got %b expected 0", extra); end
        vectors++; if (mem0[16'h0020] !== 8'h34) begin miscompares++; $display("FAIL ww_le_lo: got %h expected 34", mem0[16'h0020]); end
        vectors++; if (mem0[16'h0021] !== 8'h12) begin miscompares++; $display("FAIL ww_le_hi: got %h expected 12", mem0[16'h0021]); end
        vectors++; if (mem1[16'h0020] !== 8'h12) begin miscompares++; $display("FAIL ww_be_lo: got %h expected 12", mem1[16'h0020]); end
        vectors++; if (mem1[16'h0021] !== 8'h34) begin miscompares++; $display("FAIL ww_be_hi: got %h expected 34", mem1[16'h0021]); end
        do_req(1'b0, 1'b1, 16'h0020, 16'h0, lat, r0, r1, extra);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        vectors++; if (r0 !== 16'h1234) begin miscompares++; $display("FAIL wr_rdata_le: got %h expected 1234", r0); end
        vectors++; if (r1 !== 16'h1234) begin miscompares++; $display("FAIL wr_rdata_be: got %h expected 1234", r1); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [15:0] r0, r1;
        logic extra;
        mem0[16'hFFFF] = 8'hCD; mem0[16'h0000] = 8'hAB; mem0[16'hFFFE] = 8'h99;
        mem1[16'hFFFF] = 8'hCD; mem1[16'h0000] = 8'hAB; mem1[16'hFFFE] = 8'h99;
        do_req(1'b0, 1'b1, 16'hFFFF, 16'h0, lat, r0, r1, extra);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL wrap_latency: got %0d expected 3", lat); end
        vectors++; if (r0 !== 16'hABCD) begin miscompares++; $display("FAIL wrap_rdata_le: got %h expected abcd", r0); end
        vectors++; if (r1 !== 16'hCDAB) begin miscompares++; $display("FAIL wrap_rdata_be: got %h expected cdab", r1); end
    endtask

    task automatic test_back_to_back();
        int accepts, resps, dbl;
        logic prev;
        accepts = 0; resps = 0; dbl = 0; prev = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_word = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0;
        for (int k = 0; k < 9; k++) begin
            if (if0.req_ready === 1'b1) accepts++;
            tick();
            if (if0.resp_valid === 1'b1) begin
                resps++;
                if (prev) dbl++;
                vectors++; if (if0.resp_rdata !== 16'h00A5) begin miscompares++; $display("FAIL b2b_rdata: got %h expected 00a5", if0.resp_rdata); end
            end
            prev = (if0.resp_valid === 1'b1);
        end
        req_valid = 1'b0;
        $display("txn back-to-back byte reads: accepts=%0d responses=%0d", accepts, resps);
        vectors++; if (accepts !== 3) begin miscompares++; $display("FAIL b2b_accepts: got %0d expected 3", accepts); end
        vectors++; if (resps !== 3) begin miscompares++; $display("FAIL b2b_resps: got %0d expected 3", resps); end
        vectors++; if (dbl !== 0) begin miscompares++; $display("FAIL b2b_resp_len: got %0d expected 0", dbl); end
        vectors++; if (if0.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle: got %b expected 1", if0.req_ready); end
    endtask

    task automatic test_reset_cmd();
        int w0, rs;
        w0 = wr_cmd0; rs = 0;
        mem0[16'h0030] = 8'h77;
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b0; req_addr = 16'h0030; req_wdata = 16'h005A;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++; if (if0.mem_cmd !== READ) begin miscompares++; $display("FAIL rc_cmd_forced: got %0d expected READ", if0.mem_cmd); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (if0.resp_valid === 1'b1) rs++;
            tick();
        end
        $display("txn write aborted in command cycle addr=0030");
        vectors++; if (wr_cmd0 - w0 !== 0) begin miscompares++; $display("FAIL rc_write_cmds: got %0d expected 0", wr_cmd0 - w0); end
        vectors++; if (mem0[16'h0030] !== 8'h77) begin miscompares++; $display("FAIL rc_mem: got %h expected 77", mem0[16'h0030]); end
        vectors++; if (rs !== 0) begin miscompares++; $display("FAIL rc_resp: got %0d expected 0", rs); end
        vectors++; if (if0.req_ready !== 1'b1) begin miscompares++; $display("FAIL rc_ready: got %b expected 1", if0.req_ready); end
    endtask

    task automatic test_reset_hold();
        int rs;
        rs = 0;
        mem0[16'h0040] = 8'h11; mem0[16'h0041] = 8'h22;
        mem1[16'h0040] = 8'h11; mem1[16'h0041] = 8'h22;
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1; req_addr = 16'h0040; req_wdata = 16'hBEEF;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (if0.req_ready !== 1'b1) begin miscompares++; $display("FAIL rh_ready: got %b expected 1", if0.req_ready); end
        for (int k = 0; k < 6; k++) begin
            if (if0.resp_valid === 1'b1) rs++;
            tick();
        end
        $display("txn word write aborted in hold cycle addr=0040");
        vectors++; if (mem0[16'h0040] !== 8'hEF) begin miscompares++; $display("FAIL rh_lo_le: got %h expected ef", mem0[16'h0040]); end
        vectors++; if (mem0[16'h0041] !== 8'h22) begin miscompares++; $display("FAIL rh_hi_le: got %h expected 22", mem0[16'h0041]); end
        vectors++; if (mem1[16'h0040] !== 8'hBE) begin miscompares++; $display("FAIL rh_lo_be: got %h expected be", mem1[16'h0040]); end
        vectors++; if (mem1[16'h0041] !== 8'h22) begin miscompares++; $display("FAIL rh_hi_be: got %h expected 22", mem1[16'h0041]); end
        vectors++; if (rs !== 0) begin miscompares++; $display("FAIL rh_resp: got %0d expected 0", rs); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        pend0 = 1'b0; pend1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = 8'h0; wd1 = 8'h0;
        wr_cmd0 = 0; wr_cmd1 = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0; req_addr = '0; req_wdata = 16'h0;
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        test_reset();
        test_byte();
        test_word();
        test_wrap();
        test_back_to_back();
        test_reset_cmd();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
Memory access sequencer that sits directly upstream of the SRAM interface block (mem).
- Accepts byte or 16-bit word read/write requests from the CPU over a valid/ready handshake.
- Breaks each request into byte accesses on the mem cmd/addr/write_data/read_data interface, honouring that interface's timing: a write is commanded one cycle and performed the next, and reads are combinational.
- Returns read data, or a write acknowledge, as a one-cycle response pulse.

Parameters:
LITTLE_ENDIAN, 1, 1: low byte at addr and high byte at addr+1; 0: high byte at addr and low byte at addr+1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_write  input  1  1 = write, 0 = read.
req_word  input  1  1 = 16-bit access, 0 = byte access.
req_addr  input  addr_t  byte address of the access.
req_wdata  input  16  write data; byte access uses [7:0].
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  16  read result, valid when resp_valid=1; byte read is zero-extended; 0 for writes.
mem_cmd  output  mem_types::cmd_t  command to mem.
mem_addr  output  addr_t  address to mem.
mem_write_data  output  8  write data to mem.
mem_read_data  input  8  read data from mem.

Behaviour:
Reset values (after the reset edge):
- state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_addr=0, mem_write_data=0.
- mem_cmd=mem_types::READ.

Command rules:
- mem_cmd is combinational from state.
- It equals mem_types::WRITE only in WR_CMD_LO/WR_CMD_HI, and only while reset=0.
- It is mem_types::READ in every other case, including IDLE.
- mem_addr and mem_write_data are registered and held stable through each CMD+HOLD pair.

Acceptance:
- req_ready=1 only in IDLE.
- A request is accepted on an edge where req_valid && req_ready; all request fields are latched on that edge.

States and transitions:
- IDLE: on accept, go to RD_LO if read, else WR_CMD_LO. mem_addr/mem_write_data are loaded for the first byte on the same edge.
- RD_LO: capture mem_read_data into the first-byte slot at the end of the cycle. If word, go to RD_HI with mem_addr = addr+1; else go to RESP.
- RD_HI: capture the second byte, then go to RESP.
- WR_CMD_LO (cmd=WRITE) -> WR_HOLD_LO (cmd=READ, same addr/data; the physical write happens here). Then WR_CMD_HI if word (addr+1, second data byte), else RESP.
- WR_CMD_HI -> WR_HOLD_HI -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.

Latency, counted as cycles from the accept edge to the cycle in which resp_valid=1:
- byte read 2, word read 3.
- byte write 3, word write 5.
- Back-to-back throughput: one request per (latency+1) cycles.

Read/write separation:
- No read capture ever occurs in a cycle whose preceding cycle had mem_cmd=WRITE.
- This holds because every HOLD cycle issues READ before any read state is entered.

Addressing:
- addr+1 wraps modulo 2^width(addr_t); e.g. a word access at the all-ones address uses addr 0 for the second byte.
- Byte order follows LITTLE_ENDIAN.

Reset mid-operation:
- Reset in any state: next state is IDLE and there is no resp_valid for the aborted request.
- Reset during WR_CMD_*: mem_cmd is forced to READ that cycle, so no write occurs.
- Reset during WR_HOLD_*: that cycle's write completes with unchanged addr/data, since mem already latched WRITE. For a word write, the second byte is not written.
- A req_valid coincident with reset is ignored.

Test Plan:
- Reset, then byte write addr 0x0010 data 0xA5, then byte read 0x0010. Required: mem_cmd=WRITE exactly 1 cycle with mem_addr 0x0010 held 2 cycles; read resp_valid 2 cycles after accept with resp_rdata=0x00A5.
- Word write 0x1234 at 0x0020 with LITTLE_ENDIAN=1, then word read. Required: mem sees 0x34@0x0020 then 0x12@0x0021; write resp 5 cycles after accept; read resp_rdata=0x1234 at 3 cycles. Rerun with LITTLE_ENDIAN=0: bytes swapped in memory, readback still 0x1234.
- Word read at the all-ones address. Required: second byte access at address 0, result assembled correctly.
- req_valid held high continuously. Required: req_ready low from the accept edge until back in IDLE; no double-accept; resp_valid exactly one cycle per request.
- Reset in WR_CMD_LO. Required: no WRITE reaches mem and memory is unchanged.
- Reset in WR_HOLD_LO of a word write. Required: low byte written, high byte untouched, no resp_valid, req_ready=1 after reset.
